riscv_mem_lsu: RTL

RISCV_MEM_LSU -- requirements
Module: riscv_mem_lsu

---
 rtl/riscv_mem_lsu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/riscv_mem_lsu.sv
// RISC-V memory stage: pipeline registers, load-wait FSM and load data alignment/extension.
// Optional RISCV_MEM_MISALIGN_EN adds natural-alignment checks that raise misalign exceptions.
module riscv_mem_lsu #(
    parameter int unsigned       XLEN            = 32,
    parameter logic [XLEN-1:0]   PC_INIT         = 'h200,
    parameter int unsigned       EXCEPTION_SIZE  = 16,
    parameter int unsigned       LD_MISALIGN_BIT = 4,
    parameter int unsigned       ST_MISALIGN_BIT = 6
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wb_stall,
    input  logic [XLEN-1:0]           ex_pc,
    input  logic                      ex_bubble,
    input  logic [XLEN-1:0]           ex_instr,
    input  logic [EXCEPTION_SIZE-1:0] ex_exception,
    input  logic [EXCEPTION_SIZE-1:0] wb_exception,
    input  logic [XLEN-1:0]           ex_r,
    input  logic [XLEN-1:0]           dmem_adr,
    input  logic                      ex_load,
    input  logic                      ex_store,
    input  logic [2:0]                ex_size,
    input  logic                      dmem_ack,
    input  logic [XLEN-1:0]           dmem_q,
    output logic                      mem_stall,
    output logic [XLEN-1:0]           mem_pc,
    output logic                      mem_bubble,
    output logic [XLEN-1:0]           mem_instr,
    output logic [EXCEPTION_SIZE-1:0] mem_exception,
    output logic [XLEN-1:0]           mem_r,
    output logic [XLEN-1:0]           mem_memadr,
    output logic [XLEN-1:0]           mem_load_q
);

    localparam int unsigned      Offs     = $clog2(XLEN / 8);
    localparam logic [XLEN-1:0]  ByteMask = XLEN'(8'hFF);
    localparam logic [XLEN-1:0]  HalfMask = XLEN'(16'hFFFF);
    localparam logic [XLEN-1:0]  WordMask = XLEN'(32'hFFFF_FFFF);

    typedef enum logic {StIdle, StWait} state_e;

    state_e                    state_q, state_d;
    logic                      advance;
    logic                      flush;
    logic                      start_load;
    logic                      load_capture;
    logic [EXCEPTION_SIZE-1:0] exc_in;
    logic [2:0]                mem_size;
    logic                      mem_load;
    logic [XLEN-1:0]           shifted;
    logic [XLEN-1:0]           load_ext;

    assign mem_stall = (state_q == StWait) && !dmem_ack;
    assign advance   = !wb_stall && !mem_stall;
    assign flush     = (|mem_exception) || (|wb_exception);

`ifdef RISCV_MEM_MISALIGN_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (ex_size[1:0])
            2'd1:    misaligned = dmem_adr[0];
            2'd2:    misaligned = |dmem_adr[1:0];
            2'd3:    misaligned = (XLEN == 64) ? |dmem_adr[2:0] : |dmem_adr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        exc_in = ex_exception;
        if (!ex_bubble && misaligned) begin
            if (ex_load)  exc_in[LD_MISALIGN_BIT] = 1'b1;
            if (ex_store) exc_in[ST_MISALIGN_BIT] = 1'b1;
        end
    end
`else
    logic unused_store;

    assign exc_in       = ex_exception;
    assign unused_store = ex_store;
`endif

    // A load only waits for memory when it reaches MEM clean (no exception, no flush).
    assign start_load   = advance && !ex_bubble && ex_load && !flush && (exc_in == '0);
    assign load_capture = (state_q == StWait) && dmem_ack && mem_load;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else if (start_load) begin
            state_d = StWait;
        end else if ((state_q == StWait) && dmem_ack) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            mem_pc        <= PC_INIT;
            mem_bubble    <= 1'b1;
            mem_exception <= '0;
            mem_load_q    <= '0;
        end else begin
            state_q <= state_d;
            if (advance) mem_pc <= ex_pc;
            if (flush) begin
                mem_bubble <= 1'b1;
            end else if (advance) begin
                mem_bubble <= ex_bubble;
            end
            if (flush) begin
                mem_exception <= '0;
            end else if (!wb_stall) begin
                mem_exception <= exc_in;
            end
            if (load_capture) mem_load_q <= load_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            mem_instr  <= ex_instr;
            mem_r      <= ex_r;
            mem_memadr <= dmem_adr;
            mem_size   <= ex_size;
            mem_load   <= ex_load;
        end
    end

    // Bring the addressed byte lane down to bit 0, then truncate and extend per funct3.
    always_comb begin
        shifted  = dmem_q >> {mem_memadr[Offs-1:0], 3'b000};
        load_ext = shifted;
        case (mem_size)
            3'd0: load_ext = (shifted & ByteMask) | (shifted[7] ? ~ByteMask : '0);
            3'd1: load_ext = (shifted & HalfMask) | (shifted[15] ? ~HalfMask : '0);
            3'd2: load_ext = (shifted & WordMask) | (shifted[31] ? ~WordMask : '0);
            3'd4: load_ext = shifted & ByteMask;
            3'd5: load_ext = shifted & HalfMask;
            3'd6: load_ext = shifted & WordMask;
            default: load_ext = shifted;
        endcase
    end

endmodule
